mesh_edge_collector: RTL
========================

Name: mesh_edge_collector

Overview:
- Parametrised boundary sink for an NxM spiking mesh.
- Replaces ad-hoc XOR reduction of mesh edge outputs with buffered collection of every boundary channel.
- Each edge-router output port feeds a per-channel FIFO with back-pressure into the router's neighbour_full input.
- Channels are drained by round-robin into one ready/valid stream, with a running XOR signature, packet count and overflow accounting.

Parameters:
- NUM_CH, 8: number of boundary channels (edge router ports).
- FLIT_W, 4: flit width in bits.
- FIFO_DEPTH, 4: entries per channel FIFO; power of two, >=2.
- PTR_W, 2: log2(FIFO_DEPTH).
- CNT_W, 16: width of pkt_count and drop_count.

Ports:
- rt_clk  in  1  router clock; single clock domain.
- rt_reset  in  1  asynchronous, active-high reset.
- ch_data  in  NUM_CH*FLIT_W  boundary flits; channel i at [i*FLIT_W +: FLIT_W].
- ch_write_req  in  NUM_CH  per-channel write strobe from edge router.
- ch_full  out  NUM_CH  per-channel FIFO full; drives the router's neighbour_full.
- out_data  out  FLIT_W  collected flit.
- out_valid  out  1  out_data holds a flit.
- out_ready  in  1  consumer accepts flit.
- sig_clear  in  1  synchronous clear of signature and statistics.
- signature  out  FLIT_W  XOR of all flits transferred since clear.
- sig_parity  out  1  reduction XOR of signature.
- pkt_count  out  CNT_W  transferred flits; saturating.
- drop_count  out  CNT_W  dropped flits; saturating.
- overflow  out  NUM_CH  sticky per-channel drop flag.

Behaviour:
- Clock and reset: one clock, rt_clk. rt_reset is asynchronous, active-high.
- Reset values:
  - All FIFOs empty; ch_full=0; out_valid=0; out_data=0.
  - signature=0, sig_parity=0, pkt_count=0, drop_count=0, overflow=0.
  - RR pointer last_grant=NUM_CH-1.
- Reset asserted mid-operation discards all buffered flits immediately. No flit from before reset appears after release.
- Push:
  - A flit is accepted on a rt_clk edge when ch_write_req[i]=1 and count_i<FIFO_DEPTH.
  - ch_full[i]=(count_i==FIFO_DEPTH), decoded from registered count.
- Write while full:
  - The flit is dropped and overflow[i] is set (sticky).
  - drop_count increments by the number of channels dropping that cycle, saturating at all-ones.
  - A pop from a full FIFO in the same cycle does NOT rescue the write; full is evaluated on the pre-edge count.
- Output register: loads when (!out_valid || out_ready) and at least one FIFO is non-empty.
- Arbitration:
  - Grant goes to the first non-empty channel scanning last_grant+1, last_grant+2, ... with wrap modulo NUM_CH.
  - The granted FIFO pops; last_grant updates to the granted index.
  - When no channel is non-empty and out_ready=1, out_valid goes 0 next edge.
- Latency: a flit pushed at edge k into an empty collector with an idle output is visible (out_valid=1) after edge k+1.
  - A FIFO whose only entry is being loaded into the output cannot supply a second flit in the same cycle.
- Simultaneous push and pop on one FIFO with 0<count<FIFO_DEPTH: count unchanged, order preserved.
- Throughput: one flit per cycle at the output when out_ready is held at 1.
- Transfer (out_valid && out_ready):
  - signature <= signature ^ out_data.
  - pkt_count += 1, saturating.
  - sig_parity = ^signature, combinational from the register.
- sig_clear:
  - Zeroes signature, pkt_count, drop_count and overflow on the next edge.
  - Takes priority over a coincident transfer or drop; that event is not counted.
  - Does not flush FIFOs or the output register.
- out_data holds its last value while out_valid=0.
- Pointer wrap: read and write pointers are PTR_W bits, wrap naturally. count_i is PTR_W+1 bits.

Test Plan (NUM_CH=8, FLIT_W=4, FIFO_DEPTH=4):
- Single flit: ch_write_req[3]=1, ch_data ch3=4'hA, out_ready=1 for one edge -> out_valid=1 with out_data=4'hA after the following edge; one cycle later signature=4'hA, pkt_count=1, sig_parity=0.
- Simultaneous burst: all 8 channels write once, channel i data=i+1, out_ready=1 -> output order 1,2,...,8 on 8 consecutive cycles; signature=4'h8, pkt_count=8.
- Back-pressure/overflow: out_ready=0, ch0 writes flits 1..6 on consecutive edges:
  - flit 1 goes to the output register; FIFO holds 2..5; ch_full[0]=1 after the 5th write.
  - flit 6 is dropped: overflow[0]=1, drop_count=1.
  - then out_ready=1 -> flits 1,2,3,4,5 in order; ch_full[0] deasserts after the first FIFO pop.
- Fairness: ch1 and ch5 kept backlogged, out_ready=1 -> grants alternate 1,5,1,5; no other channel is granted.
- Clear priority: sig_clear=1 in the same cycle as a transfer and a drop -> next cycle signature=0, pkt_count=0, drop_count=0, overflow=0; buffered flits still drain afterwards.
- Reset mid-run: rt_reset asserted with 3 flits buffered and out_valid=1 -> out_valid=0 and ch_full=0 without waiting for an edge; after release, with no new writes, out_valid stays 0.

Source files
------------

// File: rtl/mesh_edge_collector.sv
// Boundary sink for a spiking mesh: per-channel FIFOs with back-pressure, drained by
// round-robin into one ready/valid stream with XOR signature and packet/drop statistics.
module mesh_edge_collector #(
  parameter int NUM_CH     = 8,
  parameter int FLIT_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                     rt_clk,
  input  logic                     rt_reset,
  input  logic [NUM_CH*FLIT_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_write_req,
  output logic [NUM_CH-1:0]        ch_full,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     sig_clear,
  output logic [FLIT_W-1:0]        signature,
  output logic                     sig_parity,
  output logic [CNT_W-1:0]         pkt_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic [NUM_CH-1:0]        overflow
);

  localparam int unsigned NCH = NUM_CH;
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(FIFO_DEPTH);

  logic [FLIT_W-1:0] mem_q [NUM_CH][FIFO_DEPTH];
  logic [PTR_W:0]    cnt_q [NUM_CH];
  logic [PTR_W:0]    cnt_d [NUM_CH];
  logic [PTR_W-1:0]  wp_q  [NUM_CH];
  logic [PTR_W-1:0]  wp_d  [NUM_CH];
  logic [PTR_W-1:0]  rp_q  [NUM_CH];
  logic [PTR_W-1:0]  rp_d  [NUM_CH];

  logic [GW-1:0]     last_q, last_d;
  logic [FLIT_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0]  pkt_q, pkt_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  logic [NUM_CH-1:0] full, nonempty, push, drop, pop;
  logic              found, load, xfer;
  logic [GW-1:0]     gnt;
  logic [CNT_W:0]    ndrop, dsum;
  int unsigned       idx;

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    ndrop = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      full[i]     = (cnt_q[i] == DEPTH);
      nonempty[i] = (cnt_q[i] != '0);
      push[i]     = ch_write_req[i] & ~full[i];
      drop[i]     = ch_write_req[i] & full[i];
      ndrop       = ndrop + {{CNT_W{1'b0}}, drop[i]};
    end
    // Scan starts one past the last grant and wraps, so the winner rotates.
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = (32'(last_q) + k) % NCH;
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        gnt   = GW'(idx);
      end
    end
    load = (!out_valid_q || out_ready) && found;
    xfer = out_valid_q && out_ready;

    for (int unsigned i = 0; i < NCH; i++) begin
      pop[i]  = load && (32'(gnt) == i);
      wp_d[i] = wp_q[i] + PTR_W'(push[i]);
      rp_d[i] = rp_q[i] + PTR_W'(pop[i]);
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end

    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (load) begin
      out_data_d  = mem_q[gnt][rp_q[gnt]];
      out_valid_d = 1'b1;
      last_d      = gnt;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    sig_d  = sig_q;
    pkt_d  = pkt_q;
    dsum   = {1'b0, drop_q} + ndrop;
    drop_d = dsum[CNT_W] ? '1 : dsum[CNT_W-1:0];
    ovf_d  = ovf_q | drop;
    if (xfer) begin
      sig_d = sig_q ^ out_data_q;
      if (pkt_q != '1) pkt_d = pkt_q + 1'b1;
    end
    if (sig_clear) begin
      sig_d  = '0;
      pkt_d  = '0;
      drop_d = '0;
      ovf_d  = '0;
    end
  end

  always_ff @(posedge rt_clk) begin
    for (int unsigned i = 0; i < NCH; i++)
      if (push[i]) mem_q[i][wp_q[i]] <= ch_data[i*FLIT_W +: FLIT_W];
  end

  always_ff @(posedge rt_clk or posedge rt_reset) begin
    if (rt_reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
      end
      last_q      <= GW'(NUM_CH - 1);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sig_q       <= '0;
      pkt_q       <= '0;
      drop_q      <= '0;
      ovf_q       <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
        wp_q[i]  <= wp_d[i];
        rp_q[i]  <= rp_d[i];
      end
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sig_q       <= sig_d;
      pkt_q       <= pkt_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ch_full    = full;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign signature  = sig_q;
  assign sig_parity = ^sig_q;
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule
